// File: rtl/riio_gpi_rx_filter.sv
// Receive-side filter for one general-purpose input pad: synchronise, invert, debounce,
// detect edges and hold a sticky interrupt with overrun flag.
module riio_gpi_rx_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_W      = 8
) (
   input  logic              CLK_I,
   input  logic              RSTN_I,
   input  logic              PAD_DI_I,
   input  logic              EN_I,
   input  logic [FILT_W-1:0] FILT_LEN_I,
   input  logic [1:0]        EDGE_SEL_I,
   input  logic              INV_I,
   input  logic              IRQ_CLR_I,
   output logic              IE_O,
   output logic              DI_O,
   output logic              RISE_O,
   output logic              FALL_O,
   output logic              IRQ_O,
   output logic              OVF_O
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [FILT_W-1:0]      cnt;
   logic [FILT_W:0]        cnt_inc;
   logic                   s;
   logic                   differs;
   logic                   commit;
   logic                   q_edge;

   // Synchroniser runs regardless of enable so the first enabled sample is already settled
   always_ff @(posedge CLK_I) begin
      if (!RSTN_I) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], PAD_DI_I};
      end
   end

   assign s       = sync_q[SYNC_STAGES-1] ^ INV_I;
   assign differs = (s != DI_O);
   // One extra bit keeps cnt+1 from wrapping, so a saturated count always commits
   assign cnt_inc = {1'b0, cnt} + {{FILT_W{1'b0}}, 1'b1};
   assign commit  = EN_I && differs && (cnt_inc >= {1'b0, FILT_LEN_I});
   assign q_edge  = (RISE_O & EDGE_SEL_I[0]) | (FALL_O & EDGE_SEL_I[1]);

   always_ff @(posedge CLK_I) begin
      if (!RSTN_I) begin
         cnt    <= '0;
         DI_O   <= 1'b0;
         RISE_O <= 1'b0;
         FALL_O <= 1'b0;
      end else begin
         RISE_O <= commit & s;
         FALL_O <= commit & ~s;
         if (!EN_I || !differs || commit) begin
            cnt <= '0;
         end else begin
            cnt <= cnt_inc[FILT_W-1:0];
         end
         if (commit) begin
            DI_O <= s;
         end
      end
   end

   // A new qualifying edge wins over a simultaneous clear so the event is never lost
   always_ff @(posedge CLK_I) begin
      if (!RSTN_I) begin
         IRQ_O <= 1'b0;
         OVF_O <= 1'b0;
      end else if (q_edge) begin
         IRQ_O <= 1'b1;
         OVF_O <= IRQ_CLR_I ? 1'b0 : (OVF_O | IRQ_O);
      end else if (IRQ_CLR_I) begin
         IRQ_O <= 1'b0;
         OVF_O <= 1'b0;
      end
   end

   always_ff @(posedge CLK_I) begin
      if (!RSTN_I) begin
         IE_O <= 1'b0;
      end else begin
         IE_O <= EN_I;
      end
   end

endmodule

// File: tb/tb_riio_gpi_rx_filter.sv
// Self-checking bench for riio_gpi_rx_filter: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a behavioural model.
module tb_riio_gpi_rx_filter;

   localparam int SYNC_STAGES = 2;
   localparam int FILT_W      = 8;

   logic              clk = 1'b0;
   logic              rstn;
   logic              pad;
   logic              en;
   logic [FILT_W-1:0] flen;
   logic [1:0]        esel;
   logic              inv;
   logic              clr;
   logic              ie_o, di_o, rise_o, fall_o, irq_o, ovf_o;

   int tests = 0;
   int fails = 0;

   // Behavioural model state
   int m_sync[$];
   int m_di, m_run, m_rise, m_fall, m_irq, m_ovf, m_ie;

   always #5 clk = ~clk;

   riio_gpi_rx_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) dut (
      .CLK_I(clk), .RSTN_I(rstn), .PAD_DI_I(pad), .EN_I(en), .FILT_LEN_I(flen),
      .EDGE_SEL_I(esel), .INV_I(inv), .IRQ_CLR_I(clr), .IE_O(ie_o), .DI_O(di_o),
      .RISE_O(rise_o), .FALL_O(fall_o), .IRQ_O(irq_o), .OVF_O(ovf_o)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Rules: the pad reaches the filter SYNC_STAGES clocks late; the output takes a new value
   // once it has disagreed with the current one for max(len,1) enabled clocks in a row.
   task automatic model_clock();
      int s, need, qual, n_di, n_run, n_rise, n_fall, n_irq, n_ovf;
      if (!rstn) begin
         m_sync.delete();
         for (int i = 0; i < SYNC_STAGES; i++) m_sync.push_back(0);
         m_di = 0; m_run = 0; m_rise = 0; m_fall = 0; m_irq = 0; m_ovf = 0; m_ie = 0;
         return;
      end
      s    = m_sync[0] ^ int'(inv);
      need = (flen == 0) ? 1 : int'(flen);
      qual = (m_rise & int'(esel[0])) | (m_fall & int'(esel[1]));
      n_di = m_di; n_run = 0; n_rise = 0; n_fall = 0;
      if (en && s != m_di) begin
         if (m_run + 1 >= need) begin
            n_di = s;
            n_rise = s;
            n_fall = 1 - s;
         end else begin
            n_run = m_run + 1;
         end
      end
      n_irq = m_irq; n_ovf = m_ovf;
      if (qual && !clr)      begin n_irq = 1; n_ovf = m_ovf | m_irq; end
      else if (qual && clr)  begin n_irq = 1; n_ovf = 0; end
      else if (clr)          begin n_irq = 0; n_ovf = 0; end
      m_di = n_di; m_run = n_run; m_rise = n_rise; m_fall = n_fall;
      m_irq = n_irq; m_ovf = n_ovf; m_ie = int'(en);
      void'(m_sync.pop_front());
      m_sync.push_back(int'(pad));
   endtask

   task automatic step();
      @(posedge clk);
      model_clock();
      #1;
      chk("ie", int'(ie_o), m_ie);
      chk("di", int'(di_o), m_di);
      chk("rise", int'(rise_o), m_rise);
      chk("fall", int'(fall_o), m_fall);
      chk("irq", int'(irq_o), m_irq);
      chk("ovf", int'(ovf_o), m_ovf);
      chk("rise_fall_excl", int'(rise_o & fall_o), 0);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Counts clocks until DI_O reaches val; a timeout is reported as a failed check.
   task automatic wait_di(input logic val, input int limit, output int n);
      n = 0;
      while (di_o !== val && n < limit) begin
         step();
         n++;
      end
      chk("wait_di_timeout", int'(di_o === val), 1);
   endtask

   initial begin
      int n, seen_rise, seen_fall, seen_pulse, hold;
      rstn = 1'b0; pad = 1'b0; en = 1'b0; flen = 8'd4; esel = 2'b01; inv = 1'b0; clr = 1'b0;
      m_sync.delete();
      for (int i = 0; i < SYNC_STAGES; i++) m_sync.push_back(0);
      m_di = 0; m_run = 0; m_rise = 0; m_fall = 0; m_irq = 0; m_ovf = 0; m_ie = 0;
      steps(2);
      chk("reset_di", int'(di_o), 0);
      chk("reset_irq", int'(irq_o), 0);

      // Reset mid-count, then latency from release
      rstn = 1'b1; en = 1'b1; pad = 1'b1;
      steps(4);
      rstn = 1'b0;
      step();
      chk("midreset_all_zero", int'({ie_o, di_o, rise_o, fall_o, irq_o, ovf_o}), 0);
      rstn = 1'b1;
      wait_di(1'b1, 20, n);
      chk("latency_len4", n, SYNC_STAGES + 4);
      chk("rise_at_commit", int'(rise_o), 1);
      step();
      chk("rise_one_cycle", int'(rise_o), 0);

      // Glitch shorter than the filter length is swallowed
      pad = 1'b0;
      wait_di(1'b0, 20, n);
      steps(2);
      pad = 1'b1; steps(3); pad = 1'b0;
      seen_pulse = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         seen_pulse |= int'(rise_o | fall_o | di_o);
      end
      chk("glitch_filtered", seen_pulse, 0);

      // Bypass with inversion, then INV_I toggle alone
      flen = 8'd0; inv = 1'b1; pad = 1'b1;
      steps(6);
      chk("inv_settled_low", int'(di_o), 0);
      pad = 1'b0;
      wait_di(1'b1, 10, n);
      chk("latency_bypass", n, SYNC_STAGES + 1);
      chk("bypass_rise", int'(rise_o), 1);
      inv = 1'b0;
      wait_di(1'b0, 10, n);
      chk("inv_toggle_fall", int'(fall_o), 1);

      // Edge select, overrun and clear race
      clr = 1'b1; step(); clr = 1'b0;
      flen = 8'd1; esel = 2'b01;
      pad = 1'b1; wait_di(1'b1, 10, n); step();
      chk("irq_after_rise", int'(irq_o), 1);
      pad = 1'b0; wait_di(1'b0, 10, n); step();
      chk("no_ovf_on_fall_sel01", int'(ovf_o), 0);
      pad = 1'b1; wait_di(1'b1, 10, n); step();
      chk("ovf_second_rise", int'(ovf_o), 1);
      esel = 2'b11;
      pad = 1'b0; wait_di(1'b0, 10, n);
      clr = 1'b1; step(); clr = 1'b0;
      chk("race_irq_kept", int'(irq_o), 1);
      chk("race_ovf_cleared", int'(ovf_o), 0);
      clr = 1'b1; step(); clr = 1'b0;
      chk("clear_alone", int'({irq_o, ovf_o}), 0);

      // Disabled: pad activity ignored
      en = 1'b0;
      step();
      chk("ie_follows_en", int'(ie_o), 0);
      seen_pulse = 0;
      for (int i = 0; i < 20; i++) begin
         pad = ~pad;
         step();
         seen_pulse |= int'(rise_o | fall_o | irq_o);
      end
      chk("disabled_no_activity", seen_pulse, 0);
      chk("disabled_di_held", int'(di_o), 0);
      pad = 1'b1; en = 1'b1;
      wait_di(1'b1, 10, n);
      chk("reenable_follows", int'(di_o), 1);

      // Randomized traffic against the model
      seen_rise = 0; seen_fall = 0;
      for (int blk = 0; blk < 600; blk++) begin
         pad  = logic'($urandom_range(0, 1));
         flen = FILT_W'($urandom_range(0, 5));
         esel = 2'($urandom_range(0, 3));
         en   = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) inv = ~inv;
         rstn = ($urandom_range(0, 99) != 0);
         hold = $urandom_range(1, 8);
         for (int c = 0; c < hold; c++) begin
            clr = ($urandom_range(0, 5) == 0);
            step();
            rstn = 1'b1;
            seen_rise += int'(rise_o);
            seen_fall += int'(fall_o);
         end
      end
      clr = 1'b0;
      chk("random_saw_rise", int'(seen_rise > 0), 1);
      chk("random_saw_fall", int'(seen_fall > 0), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
